// File: rtl/tinst_issue_queue_pkg.sv
// Shared tensor-instruction encodings and field widths for the tensor issue path.
package tinst_issue_queue_pkg;

    localparam int ADDR_WIDTH           = 64;
    localparam int TINST_TYPE_WIDTH     = 2;
    localparam int TLOAD_DATAW_WIDTH    = 3;
    localparam int TMMA_PRECISION_WIDTH = 1;

    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA       = 2'd0;
    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA   = 2'd1;
    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC   = 2'd2;
    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_POSTSTOREC = 2'd3;

    // Packed entry layout, MSB first: type, data_width, addr0, addr1, precision, acc.
    localparam int TINST_ENTRY_WIDTH = TINST_TYPE_WIDTH + TLOAD_DATAW_WIDTH + 2 * ADDR_WIDTH
                                     + TMMA_PRECISION_WIDTH + 1;

    typedef struct packed {
        logic [TINST_TYPE_WIDTH-1:0]     tinst_type;
        logic [TLOAD_DATAW_WIDTH-1:0]    data_width;
        logic [ADDR_WIDTH-1:0]           addr0;
        logic [ADDR_WIDTH-1:0]           addr1;
        logic [TMMA_PRECISION_WIDTH-1:0] precision;
        logic                            acc;
    } tinst_entry_t;

endpackage

// File: rtl/tinst_issue_queue_fifo.sv
// Generic DEPTH x WIDTH first-word fall-through FIFO with synchronous flush.
module tinst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Extra MSB on each pointer is a wrap bit that separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push && !full) wr_ptr <= wr_ptr + 1'b1;
                if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tinst_issue_queue.sv
// In-order tensor instruction issue queue between decode and the systolic-array top,
// with A-buffer hazard tracking and an issued-instruction counter.
module tinst_issue_queue
    import tinst_issue_queue_pkg::*;
#(
    parameter int DEPTH                = 4,
    parameter int ADDR_WIDTH           = tinst_issue_queue_pkg::ADDR_WIDTH,
    parameter int TINST_TYPE_WIDTH     = tinst_issue_queue_pkg::TINST_TYPE_WIDTH,
    parameter int TLOAD_DATAW_WIDTH    = tinst_issue_queue_pkg::TLOAD_DATAW_WIDTH,
    parameter int TMMA_PRECISION_WIDTH = tinst_issue_queue_pkg::TMMA_PRECISION_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            dec_tinst_valid_i,
    output logic                            dec_tinst_ready_o,
    input  logic [TINST_TYPE_WIDTH-1:0]     dec_tinst_type_i,
    input  logic [TLOAD_DATAW_WIDTH-1:0]    dec_tinst_data_width_i,
    input  logic [ADDR_WIDTH-1:0]           dec_tinst_addr0_i,
    input  logic [ADDR_WIDTH-1:0]           dec_tinst_addr1_i,
    input  logic [TMMA_PRECISION_WIDTH-1:0] dec_tinst_precision_i,
    input  logic                            dec_tinst_acc_i,
    output logic                            issue_tinst_valid_o,
    input  logic                            issue_tinst_ready_i,
    output logic [TINST_TYPE_WIDTH-1:0]     issue_tinst_type_o,
    output logic [TLOAD_DATAW_WIDTH-1:0]    issue_tinst_data_width_o,
    output logic [ADDR_WIDTH-1:0]           issue_tinst_addr0_o,
    output logic [ADDR_WIDTH-1:0]           issue_tinst_addr1_o,
    output logic [TMMA_PRECISION_WIDTH-1:0] issue_tinst_precision_o,
    output logic                            issue_tinst_acc_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            err_no_a_o,
    output logic [15:0]                     issued_cnt_o
);
    localparam int EW = TINST_TYPE_WIDTH + TLOAD_DATAW_WIDTH + 2 * ADDR_WIDTH
                      + TMMA_PRECISION_WIDTH + 1;

    logic          full, empty, push, pop, a_valid_r;
    logic [EW-1:0] push_data, head;

    // Ready ignores the issue side: a full queue never pushes through on a pop.
    assign dec_tinst_ready_o   = ~full & ~flush_i;
    assign issue_tinst_valid_o = ~empty;
    assign push = dec_tinst_valid_i & dec_tinst_ready_o;
    assign pop  = issue_tinst_valid_o & issue_tinst_ready_i;

    assign push_data = {dec_tinst_type_i, dec_tinst_data_width_i, dec_tinst_addr0_i,
                        dec_tinst_addr1_i, dec_tinst_precision_i, dec_tinst_acc_i};
    assign {issue_tinst_type_o, issue_tinst_data_width_o, issue_tinst_addr0_o,
            issue_tinst_addr1_o, issue_tinst_precision_o, issue_tinst_acc_o} = head;

    tinst_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    // A stays loaded across any number of TMMAs until a flush invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_r    <= 1'b0;
            err_no_a_o   <= 1'b0;
            issued_cnt_o <= '0;
        end else begin
            if (pop) issued_cnt_o <= issued_cnt_o + 16'd1;
            if (pop && issue_tinst_type_o == TINST_TYPE_TMMA && !a_valid_r) err_no_a_o <= 1'b1;
            if (flush_i)
                a_valid_r <= 1'b0;
            else if (pop && issue_tinst_type_o == TINST_TYPE_PRELOADA)
                a_valid_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tinst_issue_queue.sv
// Directed bench for tinst_issue_queue: vector table plus hand sequences for
// concurrent push/pop, hazard flag and asynchronous reset.
module tb_tinst_issue_queue;
    import tinst_issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, dvalid, dready, ivalid, iready;
    logic [1:0]  dtype, itype;
    logic [2:0]  ddw, idw, count;
    logic [63:0] da0, da1, ia0, ia1;
    logic        dprec, iprec, dacc, iacc, err;
    logic [15:0] issued;

    int n_cmp = 0;
    int n_fail = 0;

    tinst_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .dec_tinst_valid_i(dvalid), .dec_tinst_ready_o(dready),
        .dec_tinst_type_i(dtype), .dec_tinst_data_width_i(ddw),
        .dec_tinst_addr0_i(da0), .dec_tinst_addr1_i(da1),
        .dec_tinst_precision_i(dprec), .dec_tinst_acc_i(dacc),
        .issue_tinst_valid_o(ivalid), .issue_tinst_ready_i(iready),
        .issue_tinst_type_o(itype), .issue_tinst_data_width_o(idw),
        .issue_tinst_addr0_o(ia0), .issue_tinst_addr1_o(ia1),
        .issue_tinst_precision_o(iprec), .issue_tinst_acc_o(iacc),
        .count_o(count), .err_no_a_o(err), .issued_cnt_o(issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush, dv, rdy;
        logic [1:0]  ty;
        logic [63:0] a0, a1;
        logic        e_drdy, e_ivld, hchk, e_err;
        logic [1:0]  e_ty;
        logic [63:0] e_a0, e_a1;
        logic [2:0]  e_cnt;
        logic [15:0] e_iss;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic f, input logic dv, input logic [1:0] ty,
                                input logic [63:0] a0, input logic [63:0] a1, input logic rdy,
                                input logic e_drdy, input logic e_ivld, input logic hchk,
                                input logic [1:0] e_ty, input logic [63:0] e_a0,
                                input logic [63:0] e_a1, input logic [2:0] e_cnt,
                                input logic e_err, input logic [15:0] e_iss);
        vec_t v;
        v.flush = f; v.dv = dv; v.ty = ty; v.a0 = a0; v.a1 = a1; v.rdy = rdy;
        v.e_drdy = e_drdy; v.e_ivld = e_ivld; v.hchk = hchk; v.e_ty = e_ty;
        v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_cnt = e_cnt; v.e_err = e_err; v.e_iss = e_iss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Side fields are derived from the addresses so each entry carries distinct values.
    task automatic drive(input logic f, input logic dv, input logic [1:0] ty,
                         input logic [63:0] a0, input logic [63:0] a1, input logic rdy);
        flush = f; dvalid = dv; dtype = ty; da0 = a0; da1 = a1; iready = rdy;
        ddw = a0[2:0] ^ a1[2:0]; dprec = a1[0]; dacc = a0[0] ^ a1[0];
    endtask

    task automatic chk_head(input string tag, input logic [1:0] ty,
                            input logic [63:0] a0, input logic [63:0] a1);
        chk({tag, " type"}, 64'(itype), 64'(ty));
        chk({tag, " addr0"}, ia0, a0);
        chk({tag, " addr1"}, ia1, a1);
        chk({tag, " dw"}, 64'(idw), 64'(a0[2:0] ^ a1[2:0]));
        chk({tag, " prec"}, 64'(iprec), 64'(a1[0]));
        chk({tag, " acc"}, 64'(iacc), 64'(a0[0] ^ a1[0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [1:0] TM = TINST_TYPE_TMMA;
    localparam logic [1:0] PA = TINST_TYPE_PRELOADA;
    localparam logic [1:0] PC = TINST_TYPE_PRELOADC;
    localparam logic [1:0] PS = TINST_TYPE_POSTSTOREC;

    logic [1:0]  q_ty[$];
    logic [63:0] q_a0[$];

    initial begin
        //                f  dv ty  a0       a1       rdy  drdy ivld hchk ety e_a0     e_a1     cnt err iss
        vecs[0]  = mk(0, 1, PA, 64'h1000, 64'h0,    1,   1, 0, 0, TM, 64'h0,    64'h0,    0, 0, 0);
        vecs[1]  = mk(0, 1, TM, 64'h0,    64'h2000, 1,   1, 1, 1, PA, 64'h1000, 64'h0,    1, 0, 0);
        vecs[2]  = mk(0, 0, TM, 64'h0,    64'h0,    1,   1, 1, 1, TM, 64'h0,    64'h2000, 1, 0, 1);
        vecs[3]  = mk(0, 0, TM, 64'h0,    64'h0,    0,   1, 0, 0, TM, 64'h0,    64'h0,    0, 0, 2);
        vecs[4]  = mk(0, 1, PC, 64'h10,   64'h0,    0,   1, 0, 0, TM, 64'h0,    64'h0,    0, 0, 2);
        vecs[5]  = mk(0, 1, PC, 64'h11,   64'h0,    0,   1, 1, 1, PC, 64'h10,   64'h0,    1, 0, 2);
        vecs[6]  = mk(0, 1, PC, 64'h12,   64'h0,    0,   1, 1, 1, PC, 64'h10,   64'h0,    2, 0, 2);
        vecs[7]  = mk(0, 1, PC, 64'h13,   64'h0,    0,   1, 1, 1, PC, 64'h10,   64'h0,    3, 0, 2);
        vecs[8]  = mk(0, 1, PS, 64'h14,   64'h0,    0,   0, 1, 1, PC, 64'h10,   64'h0,    4, 0, 2);
        vecs[9]  = mk(0, 0, TM, 64'h0,    64'h0,    1,   0, 1, 1, PC, 64'h10,   64'h0,    4, 0, 2);
        vecs[10] = mk(0, 0, TM, 64'h0,    64'h0,    0,   1, 1, 1, PC, 64'h11,   64'h0,    3, 0, 3);
        vecs[11] = mk(1, 1, TM, 64'h0,    64'h3000, 0,   0, 1, 1, PC, 64'h11,   64'h0,    3, 0, 3);
        vecs[12] = mk(0, 0, TM, 64'h0,    64'h0,    0,   1, 0, 0, TM, 64'h0,    64'h0,    0, 0, 3);
        vecs[13] = mk(0, 1, TM, 64'h0,    64'h3000, 1,   1, 0, 0, TM, 64'h0,    64'h0,    0, 0, 3);
        vecs[14] = mk(0, 0, TM, 64'h0,    64'h0,    1,   1, 1, 1, TM, 64'h0,    64'h3000, 1, 0, 3);
        vecs[15] = mk(0, 0, TM, 64'h0,    64'h0,    0,   1, 0, 0, TM, 64'h0,    64'h0,    0, 1, 4);

        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        chk("rst ivalid", 64'(ivalid), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst dready", 64'(dready), 64'd1);
        chk("rst err", 64'(err), 64'd0);
        chk("rst issued", 64'(issued), 64'd0);
        chk_head("rst head", 2'd0, 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].dv, vecs[i].ty, vecs[i].a0, vecs[i].a1, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d dready", i), 64'(dready), 64'(vecs[i].e_drdy));
            chk($sformatf("v%0d ivalid", i), 64'(ivalid), 64'(vecs[i].e_ivld));
            chk($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].e_err));
            chk($sformatf("v%0d issued", i), 64'(issued), 64'(vecs[i].e_iss));
            if (vecs[i].hchk)
                chk_head($sformatf("v%0d head", i), vecs[i].e_ty, vecs[i].e_a0, vecs[i].e_a1);
        end

        // Concurrent push/pop at occupancy 2 against a scoreboard.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 1, 2'(i), 64'h100 + 64'(i), 64'h0, 0);
            q_ty.push_back(2'(i)); q_a0.push_back(64'h100 + 64'(i));
        end
        for (int i = 2; i < 12; i++) begin
            @(negedge clk);
            drive(0, 1, 2'(i), 64'h100 + 64'(i), 64'h0, 1);
            #1;
            chk($sformatf("cc%0d count", i), 64'(count), 64'd2);
            chk($sformatf("cc%0d ivalid", i), 64'(ivalid), 64'd1);
            chk_head($sformatf("cc%0d head", i), q_ty[0], q_a0[0], 64'h0);
            void'(q_ty.pop_front()); void'(q_a0.pop_front());
            q_ty.push_back(2'(i)); q_a0.push_back(64'h100 + 64'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("drain%0d head", i), ia0, q_a0[0]);
            void'(q_ty.pop_front()); void'(q_a0.pop_front());
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("cc issued", 64'(issued), 64'd16);
        chk("cc count end", 64'(count), 64'd0);

        // TMMA with no PRELOADA after reset: flagged, still issued.
        do_reset();
        chk("hz rst err", 64'(err), 64'd0);
        drive(0, 1, TM, 64'h0, 64'h4000, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("hz tmma valid", 64'(ivalid), 64'd1);
        chk("hz err before pop", 64'(err), 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("hz err after pop", 64'(err), 64'd1);
        chk("hz issued", 64'(issued), 64'd1);

        // PRELOADA then TMMA after a fresh reset: no flag.
        do_reset();
        drive(0, 1, PA, 64'h5000, 64'h0, 1);
        @(negedge clk);
        drive(0, 1, TM, 64'h0, 64'h6000, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("ok err", 64'(err), 64'd0);
        chk("ok issued", 64'(issued), 64'd2);

        // Asynchronous reset between edges with entries queued.
        @(negedge clk);
        drive(0, 1, PC, 64'h70, 64'h0, 0);
        @(negedge clk);
        drive(0, 1, PC, 64'h71, 64'h0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("ar count pre", 64'(count), 64'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar ivalid", 64'(ivalid), 64'd0);
        chk("ar count", 64'(count), 64'd0);
        chk("ar issued", 64'(issued), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, PA, 64'h55, 64'h0, 1);
        #1;
        chk("ar post no stale", 64'(ivalid), 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("ar post count", 64'(count), 64'd1);
        chk_head("ar post head", PA, 64'h55, 64'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("ar post issued", 64'(issued), 64'd1);
        chk("ar post empty", 64'(ivalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tinst_issue_queue.md
Name: tinst_issue_queue

Overview:
- Buffers decoded tensor instructions (TMMA, PRELOADA, PRELOADC, POSTSTOREC) from the tensor decode stage.
- Presents them in order, one at a time, to the systolic-array top over its issue_tinst valid/ready interface.
- Decouples decode from the long-running array operations.
- Tracks A-buffer state and flags a TMMA issued with no PRELOADA before it.

Parameters:
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- ADDR_WIDTH, 64, address field width.
- TINST_TYPE_WIDTH, 2, instruction type field width.
- TLOAD_DATAW_WIDTH, 3, preload data-width field width.
- TMMA_PRECISION_WIDTH, 1, TMMA precision field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- flush_i  in  1  drops all queued entries.
- dec_tinst_valid_i  in  1  decode has an instruction.
- dec_tinst_ready_o  out  1  queue can accept.
- dec_tinst_type_i  in  TINST_TYPE_WIDTH  instruction type.
- dec_tinst_data_width_i  in  TLOAD_DATAW_WIDTH  preload data width.
- dec_tinst_addr0_i  in  ADDR_WIDTH  addr0 (PRELOADA/PRELOADC source, POSTSTOREC destination).
- dec_tinst_addr1_i  in  ADDR_WIDTH  addr1 (TMMA B source).
- dec_tinst_precision_i  in  TMMA_PRECISION_WIDTH  TMMA precision.
- dec_tinst_acc_i  in  1  TMMA accumulate.
- issue_tinst_valid_o  out  1  head entry valid.
- issue_tinst_ready_i  in  1  array top accepts.
- issue_tinst_type_o, issue_tinst_data_width_o, issue_tinst_addr0_o, issue_tinst_addr1_o, issue_tinst_precision_o, issue_tinst_acc_o  out  same widths as the matching inputs  head entry fields.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- err_no_a_o  out  1  sticky: TMMA issued with no PRELOADA since reset/flush.
- issued_cnt_o  out  16  instructions issued, wrapping.

Behaviour:
- Storage:
  - DEPTH-entry circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits including a wrap bit.
  - full when pointer indices are equal and wrap bits differ; empty when pointers are equal.
- Push: push = dec_tinst_valid_i & dec_tinst_ready_o.
  - dec_tinst_ready_o = ~full & ~flush_i. Not a function of issue_tinst_ready_i, so no push-through when full.
  - Fields are written to the wr_ptr entry at the clock edge.
- Pop: pop = issue_tinst_valid_o & issue_tinst_ready_i.
  - issue_tinst_valid_o = ~empty.
  - Output fields come straight from the rd_ptr entry (first-word fall-through).
  - Fields are don't-care when valid is low but must not be X after reset; storage resets to 0.
- Latency: an entry pushed at edge N is valid from cycle N+1. Minimum decode-to-issue latency is 1 cycle.
- Simultaneous push and pop (not full, not empty): both happen and count is unchanged.
- Empty queue: a push is not visible to the output in the same cycle.
- Order: strict FIFO with no reordering. Once issue_tinst_valid_o is high, valid and all fields stay stable until pop.
- A-buffer tracker a_valid_r:
  - Set on pop of PRELOADA.
  - Not cleared by TMMA, so A is reusable across several TMMAs.
  - Cleared by flush_i.
  - Pop of TMMA while a_valid_r=0 sets err_no_a_o, which stays set until rst. The TMMA is still issued.
- issued_cnt_o increments on each pop and wraps 0xFFFF->0. It is not cleared by flush.
- flush_i, synchronous:
  - At the edge: pointers and a_valid_r go to 0, so count_o=0.
  - Same cycle: push is blocked because ready is low. A pop that is in progress completes and is counted; issue_tinst_valid_o is not masked.
- Reset (rst high, asynchronous):
  - Pointers, storage, a_valid_r, err_no_a_o and issued_cnt_o go to 0.
  - Outputs: dec_tinst_ready_o=1 once flush_i is low, issue_tinst_valid_o=0, count_o=0.
  - Reset mid-operation discards all entries immediately; nothing is issued afterwards.
- Type encodings come from the shared TINST_TYPE_* constants. Unknown types are queued and issued unchanged with no tracker effect.

Decomposition:
- Shared package/defines: TINST_TYPE_WIDTH, TINST_TYPE_TMMA/PRELOADA/PRELOADC/POSTSTOREC, ADDR_WIDTH, TLOAD_DATAW_WIDTH, TMMA_PRECISION_WIDTH.
- Add a packed tinst_entry layout constant (total width = type + data_width + addr0 + addr1 + precision + acc).
- One natural sub-module: tinst_fifo, a generic DEPTH x width fall-through FIFO with flush. The tracker and counters stay in tinst_issue_queue.

Test Plan:
- Basic flow, DEPTH=4: push PRELOADA addr0=0x1000 then TMMA addr1=0x2000, issue_tinst_ready_i=1 throughout -> PRELOADA valid one cycle after its push, TMMA next cycle; issued_cnt_o=2; err_no_a_o=0.
- Full:
  - Hold issue_tinst_ready_i=0 and push 4 entries -> count_o=4, dec_tinst_ready_o=0; a 5th valid is not accepted.
  - Raise ready for 1 cycle -> count_o=3, ready=1.
- Concurrent push and pop: count_o=2, valid in and ready in for 10 cycles -> count_o stays 2; outputs in exact push order (checked against scoreboard).
- Hazard flag:
  - After reset, push and issue TMMA -> err_no_a_o=1 from the cycle after pop; TMMA still issued.
  - PRELOADA then TMMA after another reset -> err_no_a_o=0.
- Flush:
  - With 3 queued and ready=0, pulse flush_i with dec valid high -> count_o=0, issue_tinst_valid_o=0 next cycle; the flush-cycle instruction is not accepted.
  - Then TMMA -> err_no_a_o=1, because a_valid_r was cleared.
- Async reset: assert rst mid-stream between edges -> issue_tinst_valid_o=0, count_o=0, issued_cnt_o=0 immediately; after deassert, normal flow resumes.
